ram_64x2048: RTL and testbench
==============================

RAM_64X2048 -- requirements
Module: ram_64x2048

Interface
REQ-001 The interface SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter DATA_W, default 64, word width in bits.
REQ-003 Parameter ADDR_W, default 11, address width; depth = 2**ADDR_W = 2048 words.
REQ-004 Port clk  input  1  rising-edge clock for all synchronous activity.
REQ-005 Port reset  input  1  asynchronous active-low reset.
REQ-006 Port address  input  ADDR_W  word address for read or write, 0..2047.
REQ-007 Port isReading  input  1  1 = read cycle, 0 = write cycle.
REQ-008 Port dataIn  input  DATA_W  write data.
REQ-009 Port dataOut  output  DATA_W  registered read data.

Function
REQ-010 Storage SHALL be an array named ram_memory of 2048 words x 64 bits, addressable word-wise only (no byte enables).
REQ-011 On rising clk with reset high and isReading=0, ram_memory[address] SHALL take dataIn; no other word changes.
REQ-012 On rising clk with reset high and isReading=1, dataOut SHALL take ram_memory[address]; memory unchanged.
REQ-013 Read latency SHALL be exactly one clock: the value sampled at edge N is visible on dataOut after edge N, until the next read edge.
REQ-014 During write cycles dataOut SHALL hold its previous value (no write-through).
REQ-015 A read of an address written on an earlier edge SHALL return the new data; there is no same-edge read/write, since isReading selects exactly one operation.
REQ-016 All 2048 addresses SHALL be valid; there is no wrap-around or out-of-range case because the address width matches the depth.
REQ-017 Inputs SHALL be sampled only at the rising clk edge; changes between edges SHALL have no effect.
REQ-018 dataOut SHALL never be X or Z after reset has been applied once.

Reset
REQ-019 While reset=0, dataOut SHALL be 0 and every ram_memory word SHALL be 0, independent of clk.
REQ-020 Reset asserted mid-operation SHALL abort the operation; the pending write SHALL NOT occur and no partial update is allowed.
REQ-021 After reset deasserts, the first rising edge SHALL perform a normal read or write.
REQ-022 Reset deassertion SHALL be synchronized to clk by the integrator; the block adds no synchronizer.

Structure
REQ-023 DATA_W, ADDR_W and DEPTH constants SHALL live in a shared package, ram_pkg, together with a word typedef, ram_word_t, of 64 bits.
REQ-024 A single sub-module, ram_word_reg, is natural: one 64-bit async-clear register with write enable, instantiated 2048 times behind an address decoder plus a 2048:1 read mux.
REQ-025 The design SHALL be flat synchronous logic with no latches and no vendor macros.

Verification
REQ-026 Assert reset=0 for 100 ns, then release -> dataOut=0; reads of addresses 0, 1023, 1024 and 2047 return 0.
REQ-027 Write 64'hff04 to 1024 (isReading=0, one rising edge) -> ram_memory[1024]=64'hff04, ram_memory[1023] stays 0, dataOut unchanged.
REQ-028 Read 1023 over 3 cycles after that write -> dataOut=0 each cycle; then read 1024 -> dataOut=64'hff04 one edge later.
REQ-029 Write 64'hDEADBEEF_CAFEF00D to 0 and 64'h1 to 2047, then read both -> exact values returned; no aliasing.
REQ-030 Drive reset low between clk edges after writing 1024 -> dataOut=0 immediately and ram_memory[1024]=0 when read after release.
REQ-031 Toggle address and dataIn between edges with isReading=0 -> only values present at the rising edge are stored.

Source files
------------

// File: rtl/ram_64x2048_pkg.sv
// ram_pkg: shared sizing constants and the word type for the 2048 x 64 RAM.
// Latency: n/a (types only); no backpressure.
package ram_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [63:0] ram_word_t;
endpackage

// File: rtl/ram_64x2048_if.sv
// ram_64x2048_if: address/command/data bundle between a requester and the RAM.
// Latency: n/a (wires only); no backpressure, one operation per clock.
interface ram_64x2048_if #(
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int ADDR_W = ram_pkg::ADDR_W
) ();
  logic [ADDR_W-1:0] address;
  logic              isReading;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;

  modport master (
    output address,
    output isReading,
    output dataIn,
    input  dataOut
  );

  modport slave (
    input  address,
    input  isReading,
    input  dataIn,
    output dataOut
  );
endinterface

// File: rtl/ram_64x2048_word_reg.sv
// ram_word_reg: one RAM word, async active-low clear, loads on writeEn.
// Latency: 1 clk write; no backpressure (always accepts).
module ram_word_reg #(
  parameter int WIDTH = ram_pkg::DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeEn,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataQ
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataQ <= '0;
    end else if (writeEn) begin
      dataQ <= dataIn;
    end
  end
endmodule

// File: rtl/ram_64x2048.sv
// ram_64x2048: 2048 x 64 single-port RAM built from clearable word registers.
// Latency: 1 clk read (registered dataOut, held on writes); no backpressure.
module ram_64x2048 #(
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int ADDR_W = ram_pkg::ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  ram_64x2048_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] ram_memory [DEPTH];
  logic [DEPTH-1:0]  wordWe;
  logic [DATA_W-1:0] dataOutQ;

  // One-hot write decoder; isReading blocks every write strobe.
  always_comb begin
    wordWe = '0;
    if (!bus.isReading) begin
      wordWe[bus.address] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : gWord
    ram_word_reg #(.WIDTH(DATA_W)) uWord (
      .clk     (clk),
      .reset   (reset),
      .writeEn (wordWe[i]),
      .dataIn  (bus.dataIn),
      .dataQ   (ram_memory[i])
    );
  end

  // Read register only loads on read cycles, so writes never disturb dataOut.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataOutQ <= '0;
    end else if (bus.isReading) begin
      dataOutQ <= ram_memory[bus.address];
    end
  end

  assign bus.dataOut = dataOutQ;
endmodule

// File: tb/tb_ram_64x2048.sv
// Directed bench for ram_64x2048: vector table plus reset/glitch sequences.
`timescale 1ns/1ps
module tb_ram_64x2048;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  ram_64x2048_if bus ();

  ram_64x2048 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        isRead;
    logic [10:0] addr;
    logic [63:0] din;
    logic [63:0] expOut;
    string       name;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Caller is at a falling edge; drive, take one rising edge, return at the next falling edge.
  task automatic cycle(input logic isRead, input logic [10:0] addr, input logic [63:0] din);
    bus.isReading = isRead;
    bus.address   = addr;
    bus.dataIn    = din;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.isReading = 1'b1;
    bus.address   = 11'd0;
    bus.dataIn    = 64'd0;

    vecs[0]  = '{1'b1, 11'd0,    64'd0,                    64'd0,                    "rst_rd0"};
    vecs[1]  = '{1'b1, 11'd1023, 64'd0,                    64'd0,                    "rst_rd1023"};
    vecs[2]  = '{1'b1, 11'd1024, 64'd0,                    64'd0,                    "rst_rd1024"};
    vecs[3]  = '{1'b1, 11'd2047, 64'd0,                    64'd0,                    "rst_rd2047"};
    vecs[4]  = '{1'b0, 11'd1024, 64'hff04,                 64'd0,                    "wr1024_hold"};
    vecs[5]  = '{1'b1, 11'd1023, 64'd0,                    64'd0,                    "rd1023_a"};
    vecs[6]  = '{1'b1, 11'd1023, 64'd0,                    64'd0,                    "rd1023_b"};
    vecs[7]  = '{1'b1, 11'd1023, 64'd0,                    64'd0,                    "rd1023_c"};
    vecs[8]  = '{1'b1, 11'd1024, 64'd0,                    64'hff04,                 "rd1024"};
    vecs[9]  = '{1'b0, 11'd0,    64'hDEADBEEF_CAFEF00D,    64'hff04,                 "wr0_hold"};
    vecs[10] = '{1'b0, 11'd2047, 64'h1,                    64'hff04,                 "wr2047_hold"};
    vecs[11] = '{1'b1, 11'd0,    64'd0,                    64'hDEADBEEF_CAFEF00D,    "rd0"};
    vecs[12] = '{1'b1, 11'd2047, 64'd0,                    64'h1,                    "rd2047"};
    vecs[13] = '{1'b1, 11'd1024, 64'd0,                    64'hff04,                 "rd1024_again"};
    vecs[14] = '{1'b1, 11'd1,    64'd0,                    64'd0,                    "rd1_noalias"};
    vecs[15] = '{1'b1, 11'd2046, 64'd0,                    64'd0,                    "rd2046_noalias"};

    // Clock keeps running under reset; output must stay cleared.
    #95;
    check("dout_in_reset", bus.dataOut, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    check("dout_after_release", bus.dataOut, 64'd0);

    foreach (vecs[i]) begin
      cycle(vecs[i].isRead, vecs[i].addr, vecs[i].din);
      check(vecs[i].name, bus.dataOut, vecs[i].expOut);
    end

    // Only the values present at the rising edge get stored.
    bus.isReading = 1'b0;
    bus.address   = 11'd5;
    bus.dataIn    = 64'hAAAA;
    #2;
    bus.address   = 11'd6;
    bus.dataIn    = 64'hBBBB;
    #2;
    bus.address   = 11'd7;
    bus.dataIn    = 64'hCCCC;
    @(posedge clk);
    @(negedge clk);
    check("glitch_wr_hold", bus.dataOut, 64'd0);
    cycle(1'b1, 11'd5, 64'd0);
    check("glitch_rd5", bus.dataOut, 64'd0);
    cycle(1'b1, 11'd6, 64'd0);
    check("glitch_rd6", bus.dataOut, 64'd0);
    cycle(1'b1, 11'd7, 64'd0);
    check("glitch_rd7", bus.dataOut, 64'hCCCC);

    // Read address flips between edges; the edge value wins.
    bus.isReading = 1'b1;
    bus.address   = 11'd7;
    #2;
    bus.address   = 11'd0;
    @(posedge clk);
    #1;
    bus.address   = 11'd7;
    @(negedge clk);
    check("glitch_rd_addr", bus.dataOut, 64'hDEADBEEF_CAFEF00D);

    // Reset dropped between edges aborts a pending write and clears everything.
    cycle(1'b1, 11'd1024, 64'd0);
    check("pre_reset_rd1024", bus.dataOut, 64'hff04);
    bus.isReading = 1'b0;
    bus.address   = 11'd1024;
    bus.dataIn    = 64'h5555;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_dout", bus.dataOut, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("reset_held_dout", bus.dataOut, 64'd0);
    reset = 1'b1;

    // First edge after release is a normal write.
    cycle(1'b0, 11'd3, 64'h77);
    check("post_rst_wr_hold", bus.dataOut, 64'd0);
    cycle(1'b1, 11'd3, 64'd0);
    check("post_rst_rd3", bus.dataOut, 64'h77);
    cycle(1'b1, 11'd1024, 64'd0);
    check("post_rst_rd1024", bus.dataOut, 64'd0);
    cycle(1'b1, 11'd0, 64'd0);
    check("post_rst_rd0", bus.dataOut, 64'd0);
    cycle(1'b1, 11'd2047, 64'd0);
    check("post_rst_rd2047", bus.dataOut, 64'd0);
    cycle(1'b1, 11'd7, 64'd0);
    check("post_rst_rd7", bus.dataOut, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
